// File: rtl/manch_pkg.sv
// Shared Manchester definitions for the RFID receive demodulator and the
// transmit-side encoder: default bit timing, bit encoding and FSM states.
package manch_pkg;

    localparam int ETU_CYC_DEF = 16;
    localparam int TOL_DEF     = 4;

    // Logic 1 is high-then-low (falling mid-bit edge), logic 0 is low-then-high.
    localparam logic BIT_ON_FALL = 1'b1;
    localparam logic BIT_ON_RISE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SOF  = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Inclusive window test on a cycle distance.
    function automatic logic in_window(input int val, input int lo, input int hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/manch_demod_if.sv
// Line input and decoded-word outputs of the Manchester demodulator.
// master = the side driving the line (framing/test side), slave = the decoder.
interface manch_demod_if #(
    parameter int DW = 8
);
    logic          in_enable;
    logic          in_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_eof;
    logic          out_err;
    logic          out_busy;

    modport master (
        output in_enable, in_data,
        input  out_data, out_valid, out_eof, out_err, out_busy
    );

    modport slave (
        input  in_enable, in_data,
        output out_data, out_valid, out_eof, out_err, out_busy
    );
endinterface

// File: rtl/manch_sync_edge.sv
// Two-flop synchronizer for the asynchronous Manchester line, followed by a
// registered level and registered rise/fall pulses. A line change first
// sampled at edge t shows up on level/rise/fall at edge t+2.
module manch_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic sync_p0, sync_p1;
    logic lvl_p2, rise_p2, fall_p2;

    // Synchronize the line, then register its level and edge pulses together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            lvl_p2  <= 1'b0;
            rise_p2 <= 1'b0;
            fall_p2 <= 1'b0;
        end else begin
            // p0 -> p1: metastability filter
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            // p1 -> p2: level and edges aligned in time
            lvl_p2  <= sync_p1;
            rise_p2 <= sync_p1 & ~lvl_p2;
            fall_p2 <= ~sync_p1 & lvl_p2;
        end
    end

    assign level = lvl_p2;
    assign rise  = rise_p2;
    assign fall  = fall_p2;

endmodule

// File: rtl/manch_demod.sv
// Manchester decoder: tracks mid-bit transitions against the nominal ETU
// with a +/-TOL window, assembles bits LSB-first into DW-bit words and
// reports word-valid, clean end-of-frame and coding-error pulses.
module manch_demod
    import manch_pkg::*;
#(
    parameter int ETU_CYC = ETU_CYC_DEF,
    parameter int TOL     = TOL_DEF,
    parameter int DW      = 8
) (
    input logic          clk,
    input logic          in_rst_n,
    manch_demod_if.slave bus
);
    localparam int CW      = $clog2(2 * ETU_CYC + 1);
    localparam int BW      = (DW > 1) ? $clog2(DW) : 1;
    localparam int HALF_LO = ETU_CYC / 2 - TOL;
    localparam int HALF_HI = ETU_CYC / 2 + TOL;
    localparam int MID_LO  = ETU_CYC - TOL;
    localparam int MID_HI  = ETU_CYC + TOL;
    localparam int TIMEOUT = ETU_CYC + TOL + 1;
    localparam int LOW_RUN = 2 * ETU_CYC;

    localparam logic [CW-1:0] CNT_MAX  = CW'(2 * ETU_CYC);
    localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

    logic clr_n;
    logic line_lvl, line_rise, line_fall, line_edge;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [DW-1:0] shreg_q, shreg_d, word;
    logic [DW-1:0] data_q, data_d;
    logic          got_q, got_d;
    logic          valid_q, valid_d;
    logic          eof_q, eof_d;
    logic          err_q, err_d;
    logic          new_bit;
    int            elapsed;

    // Soft clear and reset both flush the synchronizer and the control state.
    assign clr_n = in_rst_n & bus.in_enable;

    manch_sync_edge u_sync (
        .clk   (clk),
        .rst_n (clr_n),
        .din   (bus.in_data),
        .level (line_lvl),
        .rise  (line_rise),
        .fall  (line_fall)
    );

    assign line_edge = line_rise | line_fall;

    // cnt is zeroed on the accepted edge, so the distance seen this cycle is cnt+1.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    assign elapsed = int'(cnt_q) + 1;

    // Next-state, counters, bit assembly and output pulses.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_inc;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        got_d    = got_q;
        valid_d  = 1'b0;
        eof_d    = 1'b0;
        err_d    = 1'b0;
        word     = shreg_q;
        new_bit  = line_fall ? BIT_ON_FALL : BIT_ON_RISE;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (line_rise) begin
                    state_d  = SOF;
                    bitcnt_d = '0;
                    got_d    = 1'b0;
                end
            end

            SOF: begin
                if (line_fall && in_window(elapsed, HALF_LO, HALF_HI)) begin
                    state_d  = DATA;
                    cnt_d    = '0;
                    bitcnt_d = '0;
                end else if (line_edge || elapsed > HALF_HI) begin
                    state_d = ERR;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end
            end

            DATA: begin
                if (line_edge) begin
                    // Where the two windows touch, the mid-bit interpretation wins
                    // so that a mid edge arriving TOL early is still decoded.
                    if (in_window(elapsed, MID_LO, MID_HI)) begin
                        word[bitcnt_q] = new_bit;
                        shreg_d        = word;
                        cnt_d          = '0;
                        if (bitcnt_q == BIT_LAST) begin
                            bitcnt_d = '0;
                            data_d   = word;
                            valid_d  = 1'b1;
                            got_d    = 1'b1;
                        end else begin
                            bitcnt_d = bitcnt_q + BW'(1);
                        end
                    end else if (!in_window(elapsed, HALF_LO, HALF_HI)) begin
                        state_d = ERR;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                    end
                end else if (elapsed >= TIMEOUT) begin
                    if (!line_lvl && bitcnt_q == '0 && got_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        eof_d   = 1'b1;
                    end else begin
                        state_d = ERR;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                    end
                end
            end

            ERR: begin
                // In ERR, cnt measures the current unbroken run of low line samples.
                if (line_lvl) begin
                    cnt_d = '0;
                end else if (elapsed >= LOW_RUN) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control state and output pulses; cleared by reset or soft clear.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            got_q    <= 1'b0;
            valid_q  <= 1'b0;
            eof_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            got_q    <= got_d;
            valid_q  <= valid_d;
            eof_q    <= eof_d;
            err_q    <= err_d;
        end
    end

    // Partial-word shift register; every position is written before it is delivered.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    // Delivered word: zeroed by reset, held across soft clear.
    always_ff @(posedge clk) begin
        if (!in_rst_n) begin
            data_q <= '0;
        end else if (bus.in_enable) begin
            data_q <= data_d;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_eof   = eof_q;
    assign bus.out_err   = err_q;
    assign bus.out_busy  = (state_q != IDLE);

endmodule
